// File: rtl/rtc_read_sequencer.sv
// rtc_read_sequencer: address-write then data-read transaction generator for the RTC multiplexed bus.
// Optional macro RTC_RD_DBLCHK_EN repeats the read until two consecutive captures agree (at most 3 reads).
module rtc_read_sequencer #(
  parameter int DATA_W  = 8,
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] ad_in,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic              ad_n,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_vld,
  output logic              rd_err
);

  localparam int T_MAX = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int CNT_W = $clog2(T_MAX) + 1;
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // S_ACPT is the single idle-bus cycle between accepting a request and driving the address.
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ACPT  = 4'd1,
    S_A_SET = 4'd2,
    S_A_STB = 4'd3,
    S_A_HLD = 4'd4,
    S_TURN  = 4'd5,
    S_D_STB = 4'd6,
    S_D_HLD = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_s;
  logic [DATA_W-1:0] addr_r;
  logic [DATA_W-1:0] cap_r;
  logic              accept_s;
  logic              phase_end_s;
  logic              cs_n_s;
  logic              rd_n_s;
  logic              wr_n_s;
  logic              ad_n_s;
  logic              ad_oe_s;
  logic              busy_s;
  logic              vld_s;
`ifdef RTC_RD_DBLCHK_EN
  logic              again_s;
  logic              err_s;
  logic [1:0]        rd_num_r;
  logic [DATA_W-1:0] prev_r;
`endif

  // Next-state and phase down-counter
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    accept_s    = 1'b0;
    phase_end_s = (cnt_r == CNT_ZERO);
`ifdef RTC_RD_DBLCHK_EN
    again_s     = 1'b0;
    err_s       = 1'b0;
`endif
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = S_ACPT;
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_ACPT: begin
        state_s = S_A_SET;
        cnt_s   = LD_SETUP;
      end
      S_A_SET: begin
        if (phase_end_s) begin
          state_s = S_A_STB;
          cnt_s   = LD_PULSE;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      S_A_STB: begin
        if (phase_end_s) begin
          state_s = S_A_HLD;
          cnt_s   = LD_SETUP;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      S_A_HLD: begin
        if (phase_end_s) begin
          state_s = S_TURN;
          cnt_s   = LD_SETUP;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      S_TURN: begin
        if (phase_end_s) begin
          state_s = S_D_STB;
          cnt_s   = LD_PULSE;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      S_D_STB: begin
        if (phase_end_s) begin
          state_s = S_D_HLD;
          cnt_s   = LD_SETUP;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      S_D_HLD: begin
        if (phase_end_s) begin
`ifdef RTC_RD_DBLCHK_EN
          // First read has nothing to compare against; a 3rd mismatch gives up with an error.
          if (rd_num_r == 2'd1) begin
            again_s = 1'b1;
          end else if (cap_r == prev_r) begin
            state_s = S_DONE;
          end else if (rd_num_r == 2'd3) begin
            state_s = S_DONE;
            err_s   = 1'b1;
          end else begin
            again_s = 1'b1;
          end
          if (again_s) begin
            state_s = S_A_SET;
            cnt_s   = LD_SETUP;
          end else begin
            cnt_s   = cnt_r;
          end
`else
          state_s = S_DONE;
`endif
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Bus pin decode of the state being entered, so the output flops line up with state_r
  always_comb begin
    cs_n_s  = 1'b1;
    rd_n_s  = 1'b1;
    wr_n_s  = 1'b1;
    ad_n_s  = 1'b1;
    ad_oe_s = 1'b0;
    busy_s  = 1'b1;
    vld_s   = 1'b0;
    case (state_s)
      S_IDLE: begin
        busy_s = 1'b0;
      end
      S_ACPT: begin
        busy_s = 1'b1;
      end
      S_A_SET: begin
        cs_n_s  = 1'b0;
        ad_n_s  = 1'b0;
        ad_oe_s = 1'b1;
      end
      S_A_STB: begin
        cs_n_s  = 1'b0;
        wr_n_s  = 1'b0;
        ad_n_s  = 1'b0;
        ad_oe_s = 1'b1;
      end
      S_A_HLD: begin
        ad_n_s  = 1'b0;
        ad_oe_s = 1'b1;
      end
      S_TURN: begin
        busy_s = 1'b1;
      end
      S_D_STB: begin
        cs_n_s = 1'b0;
        rd_n_s = 1'b0;
      end
      S_D_HLD: begin
        busy_s = 1'b1;
      end
      S_DONE: begin
        busy_s = 1'b0;
        vld_s  = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // State, counter, latched address and bus capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= CNT_ZERO;
      addr_r  <= {DATA_W{1'b0}};
      cap_r   <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        addr_r <= addr;
      end
      // Sample on the last strobe cycle, while rd_n is still low.
      if ((state_r == S_D_STB) && phase_end_s) begin
        cap_r <= ad_in;
      end
    end
  end

  // Registered bus and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_n     <= 1'b1;
      rd_n     <= 1'b1;
      wr_n     <= 1'b1;
      ad_n     <= 1'b1;
      ad_oe    <= 1'b0;
      ad_out   <= {DATA_W{1'b0}};
      busy     <= 1'b0;
      data_vld <= 1'b0;
      data_out <= {DATA_W{1'b0}};
    end else begin
      cs_n     <= cs_n_s;
      rd_n     <= rd_n_s;
      wr_n     <= wr_n_s;
      ad_n     <= ad_n_s;
      ad_oe    <= ad_oe_s;
      ad_out   <= ad_oe_s ? addr_r : {DATA_W{1'b0}};
      busy     <= busy_s;
      data_vld <= vld_s;
      if (vld_s) begin
        data_out <= cap_r;
      end
    end
  end

`ifdef RTC_RD_DBLCHK_EN
  // Read-retry bookkeeping and sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_num_r <= 2'd0;
      prev_r   <= {DATA_W{1'b0}};
      rd_err   <= 1'b0;
    end else begin
      if (accept_s) begin
        rd_num_r <= 2'd1;
        rd_err   <= 1'b0;
      end else if (again_s) begin
        rd_num_r <= rd_num_r + 2'd1;
        prev_r   <= cap_r;
      end else if (err_s) begin
        rd_err   <= 1'b1;
      end
    end
  end
`else
  assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Directed, table-driven bench for rtc_read_sequencer; per-cycle snapshots compared to hand-built windows.
`timescale 1ns/1ps
module tb_rtc_read_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] ad_in = 8'hA5;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       ad_n;
  logic       busy;
  logic [7:0] data_out;
  logic       data_vld;
  logic       rd_err;

  rtc_read_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .ad_n(ad_n), .busy(busy), .data_out(data_out), .data_vld(data_vld), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       ad_n;
    logic       ad_oe;
    logic       busy;
    logic       data_vld;
    logic       rd_err;
    logic [7:0] ad_out;
    logic [7:0] data_out;
  } snap_t;

  typedef struct {
    int   lo;
    int   hi;
    logic cs_n;
    logic wr_n;
    logic rd_n;
    logic ad_n;
    logic ad_oe;
    logic busy;
    logic vld;
  } win_t;

  snap_t      snaps [0:79];
  win_t       tbl [8];
  int         cap_cyc [4];
  logic [7:0] cap_val [4];
  int         checks = 0;
  int         failures = 0;
  int         viol = 0;
  logic       prev_cs_n = 1'b1;
  logic       prev_ad_n = 1'b1;

  // Bus-safety watch: strobes exclusive, no drive while reading, ad_n moves only after deselect
  always @(negedge clk) begin
    if (!reset) begin
      if ((!wr_n && !rd_n) || (ad_oe && !rd_n) || ((ad_n != prev_ad_n) && !prev_cs_n)) begin
        viol <= viol + 1;
      end
    end
    prev_cs_n <= cs_n;
    prev_ad_n <= ad_n;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_caps(input int c0, input logic [7:0] v0, input int c1, input logic [7:0] v1,
                          input int c2, input logic [7:0] v2);
    cap_cyc[0] = c0; cap_val[0] = v0;
    cap_cyc[1] = c1; cap_val[1] = v1;
    cap_cyc[2] = c2; cap_val[2] = v2;
    cap_cyc[3] = -1; cap_val[3] = 8'h00;
  endtask

  // Starts a request before the next edge (edge 0) and snapshots cycles 0..ncyc-1
  task automatic run(input logic [7:0] a0, input logic [7:0] a1, input int ncyc, input bit hold,
                     input int p0, input int p1);
    addr  = a0;
    start = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      snaps[k].cs_n     = cs_n;
      snaps[k].wr_n     = wr_n;
      snaps[k].rd_n     = rd_n;
      snaps[k].ad_n     = ad_n;
      snaps[k].ad_oe    = ad_oe;
      snaps[k].busy     = busy;
      snaps[k].data_vld = data_vld;
      snaps[k].rd_err   = rd_err;
      snaps[k].ad_out   = ad_out;
      snaps[k].data_out = data_out;
      addr  = a1;
      start = hold || (k == p0) || (k == p1);
      ad_in = 8'hA5;
      for (int r = 0; r < 4; r++) begin
        if (cap_cyc[r] == k) ad_in = cap_val[r];
      end
    end
    start = 1'b0;
  endtask

  task automatic cmp_txn(input int tag, input int base, input logic [7:0] a);
    for (int i = 0; i < 8; i++) begin
      for (int k = tbl[i].lo; k <= tbl[i].hi; k++) begin
        snap_t s;
        s = snaps[base + k];
        chk($sformatf("t%0d_ctl_c%0d", tag, base + k),
            {25'd0, s.cs_n, s.wr_n, s.rd_n, s.ad_n, s.ad_oe, s.busy, s.data_vld},
            {25'd0, tbl[i].cs_n, tbl[i].wr_n, tbl[i].rd_n, tbl[i].ad_n, tbl[i].ad_oe, tbl[i].busy, tbl[i].vld});
        if (tbl[i].ad_oe) begin
          chk($sformatf("t%0d_adout_c%0d", tag, base + k), {24'd0, s.ad_out}, {24'd0, a});
        end
      end
    end
  endtask

  function automatic int count_vld(input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) begin
      if (snaps[k].data_vld) n++;
    end
    return n;
  endfunction

  function automatic int count_rd(input int hi);
    int n = 0;
    for (int k = 1; k <= hi; k++) begin
      if (!snaps[k].rd_n && snaps[k-1].rd_n) n++;
    end
    return n;
  endfunction

  initial begin
    //            lo  hi  cs   wr   rd   ad_n oe   busy vld
    tbl[0] = '{ 0,  0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{ 1,  2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{ 3,  6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{ 7,  8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{ 9, 10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{11, 14, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{15, 16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{17, 17, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_ctl", {24'd0, cs_n, rd_n, wr_n, ad_n, ad_oe, busy, data_vld, rd_err}, {24'd0, 8'b1111_0000});
    chk("rst_ad_out", {24'd0, ad_out}, 32'd0);
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

`ifndef RTC_RD_DBLCHK_EN
    // Basic read of register 0x21
    set_caps(14, 8'h59, -1, 8'h00, -1, 8'h00);
    run(8'h21, 8'h21, 18, 1'b0, -1, -1);
    cmp_txn(1, 0, 8'h21);
    chk("t1_data_out", {24'd0, snaps[17].data_out}, 32'h59);
    chk("t1_vld_count", count_vld(0, 17), 32'd1);
    repeat (3) @(negedge clk);
    chk("t1_data_held", {23'd0, data_vld, data_out}, 32'h059);

    // Start pulses and address changes while busy are ignored
    set_caps(14, 8'h3C, -1, 8'h00, -1, 8'h00);
    run(8'h44, 8'h7E, 24, 1'b0, 3, 10);
    cmp_txn(2, 0, 8'h44);
    chk("t2_data_out", {24'd0, snaps[17].data_out}, 32'h3C);
    chk("t2_vld_count", count_vld(0, 23), 32'd1);
    chk("t2_idle_after", {31'd0, snaps[21].busy}, 32'd0);

    // start held high: back-to-back, 18 cycles apart
    set_caps(14, 8'h5A, 32, 8'hA7, -1, 8'h00);
    run(8'h22, 8'h23, 36, 1'b1, -1, -1);
    cmp_txn(3, 0, 8'h22);
    cmp_txn(3, 18, 8'h23);
    chk("t3_data0", {24'd0, snaps[17].data_out}, 32'h5A);
    chk("t3_data1", {24'd0, snaps[35].data_out}, 32'hA7);
    chk("t3_vld_count", count_vld(0, 35), 32'd2);
    repeat (2) @(negedge clk);
`else
    // Retry until match: 0x10, 0x11, 0x11
    set_caps(14, 8'h10, 30, 8'h11, 46, 8'h11);
    run(8'h0B, 8'h0B, 52, 1'b0, -1, -1);
    chk("t5_vld_c49", {31'd0, snaps[49].data_vld}, 32'd1);
    chk("t5_vld_count", count_vld(0, 51), 32'd1);
    chk("t5_reads", count_rd(51), 32'd3);
    chk("t5_data_err", {23'd0, snaps[49].rd_err, snaps[49].data_out}, 32'h011);

    // Never agrees: 0x01, 0x02, 0x03
    set_caps(14, 8'h01, 30, 8'h02, 46, 8'h03);
    run(8'h0C, 8'h0C, 52, 1'b0, -1, -1);
    chk("t6_vld_count", count_vld(0, 51), 32'd1);
    chk("t6_reads", count_rd(51), 32'd3);
    chk("t6_data_err", {23'd0, snaps[49].rd_err, snaps[49].data_out}, 32'h103);
    repeat (2) @(negedge clk);
    chk("t6_err_held", {31'd0, rd_err}, 32'd1);

    // Next request clears rd_err and completes at best-case latency
    set_caps(14, 8'h55, 30, 8'h55, -1, 8'h00);
    run(8'h0D, 8'h0D, 36, 1'b0, -1, -1);
    chk("t6b_err_clear", {31'd0, snaps[0].rd_err}, 32'd0);
    chk("t6b_vld_c33", {31'd0, snaps[33].data_vld}, 32'd1);
    chk("t6b_vld_count", count_vld(0, 35), 32'd1);
    chk("t6b_data_err", {23'd0, snaps[33].rd_err, snaps[33].data_out}, 32'h055);
    repeat (2) @(negedge clk);
`endif

    // Reset during the data strobe
    set_caps(14, 8'hC3, -1, 8'h00, -1, 8'h00);
    run(8'h31, 8'h31, 12, 1'b0, -1, -1);
    @(negedge clk);
    chk("t4_in_dstb", {30'd0, rd_n, cs_n}, 32'd0);
    reset = 1'b1;
    #1;
    chk("t4_rst_ctl", {25'd0, cs_n, rd_n, wr_n, ad_n, ad_oe, busy, data_vld}, {25'd0, 7'b1111000});
    chk("t4_rst_data", {24'd0, data_out}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    begin
      int nv = 0;
      int nb = 0;
      for (int k = 0; k < 25; k++) begin
        @(negedge clk);
        if (data_vld) nv++;
        if (busy) nb++;
      end
      chk("t4_no_vld", nv, 32'd0);
      chk("t4_no_busy", nb, 32'd0);
    end

    chk("bus_safety", viol, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
